spi_frame_streamer: RTL

- SPI mode-0 slave that streams a synthetic 64x64 8-bit test frame to the external host on MISO.
- It is the data-path stage next to the SCLK activity detector in the camera64x64 dummy, and is driven by the same host SCLK.
- All SPI inputs are oversampled in the system clock domain. There is no logic clocked by SCLK.

---
 rtl/spi_frame_streamer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/spi_frame_streamer.sv
// SPI mode-0 slave streaming a synthetic 64x64 8-bit test frame on MISO.
// SCLK, CS_N and MOSI are oversampled in the CLK domain; nothing runs on SCLK.
module spi_frame_streamer #(
    parameter logic [7:0] CMD_FRAME  = 8'hA5,
    parameter logic [7:0] CMD_STATUS = 8'h5A,
    parameter int         FRAME_PIX  = 4096
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCLK,
    input  logic       CS_N,
    input  logic       MOSI,
    output logic       MISO,
    output logic       BUSY,
    output logic       FRAME_DONE,
    output logic [7:0] FRAME_CNT
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        FRAME,
        STATUS,
        DRAIN
    } state_t;

    localparam logic [11:0] LAST_PIX = 12'(FRAME_PIX - 1);

    state_t      state;
    state_t      state_next;

    logic        sclk_s1, sclk_s2, sclk_h;
    logic        cs_s1, cs_s2, cs_h;
    logic        mosi_s1, mosi_s2, mosi_h;

    logic        rise, fall, cs_fall, cs_rise;
    logic        byte_end, frame_end;

    logic [2:0]  bit_cnt;
    logic [6:0]  rx_sr;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_sr;
    logic [11:0] pix_idx;
    logic        last_loaded;
    logic        done_q;
    logic [7:0]  frame_cnt;
    logic [7:0]  pix_val;

    // Two-flop synchronizers plus one history flop per SPI input
    always_ff @(posedge CLK) begin
        if (RST) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_h  <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_h    <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            mosi_h  <= 1'b0;
        end else begin
            sclk_s1 <= SCLK;
            sclk_s2 <= sclk_s1;
            sclk_h  <= sclk_s2;
            cs_s1   <= CS_N;
            cs_s2   <= cs_s1;
            cs_h    <= cs_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;
            mosi_h  <= mosi_s2;
        end
    end

    // Edge events, byte completion and pixel generation
    always_comb begin
        rise      = sclk_s2 & ~sclk_h;
        fall      = ~sclk_s2 & sclk_h;
        cs_fall   = ~cs_s2 & cs_h;
        cs_rise   = cs_s2 & ~cs_h;
        rx_byte   = {rx_sr, mosi_h};
        // chip-select edges take priority over a coincident SCLK rise
        byte_end  = rise & ~cs_rise & ~cs_fall & (bit_cnt == 3'd7);
        frame_end = byte_end & (state == FRAME) & last_loaded;
        pix_val   = {pix_idx[11:6] ^ pix_idx[5:0], 2'b00} + frame_cnt;
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (cs_rise) begin
            state_next = IDLE;
        end else if (cs_fall) begin
            state_next = CMD;
        end else if (byte_end) begin
            case (state)
                CMD: begin
                    if (rx_byte == CMD_FRAME) begin
                        state_next = FRAME;
                    end else if (rx_byte == CMD_STATUS) begin
                        state_next = STATUS;
                    end else begin
                        state_next = DRAIN;
                    end
                end
                FRAME: begin
                    if (last_loaded) begin
                        state_next = DRAIN;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    // Outputs
    always_comb begin
        BUSY       = (state != IDLE);
        MISO       = tx_sr[7];
        FRAME_DONE = done_q;
        FRAME_CNT  = frame_cnt;
    end

    // Shift registers, bit counter, pixel index and frame counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt     <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            pix_idx     <= '0;
            last_loaded <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            done_q <= frame_end;
            if (frame_end) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (cs_rise || cs_fall) begin
                bit_cnt     <= '0;
                tx_sr       <= '0;
                pix_idx     <= '0;
                last_loaded <= 1'b0;
            end else begin
                if (rise) begin
                    rx_sr   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_end && ((state == CMD) || frame_end)) begin
                    pix_idx     <= '0;
                    last_loaded <= 1'b0;
                end
                if (fall) begin
                    if (bit_cnt == 3'd0) begin
                        case (state)
                            FRAME: begin
                                tx_sr <= pix_val;
                                // hold at the last pixel; the index wraps on the move to DRAIN
                                if (pix_idx == LAST_PIX) begin
                                    last_loaded <= 1'b1;
                                end else begin
                                    pix_idx <= pix_idx + 12'd1;
                                end
                            end
                            STATUS:  tx_sr <= frame_cnt;
                            default: tx_sr <= '0;
                        endcase
                    end else begin
                        tx_sr <= {tx_sr[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule
